cpu_interrupt_unit: RTL and testbench
=====================================

Name: cpu_interrupt_unit

Overview:
- Initiator side of the pipeline's `int_ack` interface.
- Synchronises external interrupt lines and latches them into a pending register.
- Selects the highest-priority enabled source and waits for a safe pipeline point.
- Issues a one-cycle `int_ack`, which flushes D/E/M, together with the trap cause and the restart PC for the CSR file and PC-select logic.

Parameters:
- NUM_IRQ, 4: number of interrupt sources, 1..16.
- EDGE_MASK, 0: bit i=1 makes source i rising-edge triggered; bit i=0 makes it level triggered.
- SYNC_STAGES, 2: flip-flop synchroniser depth per irq line, >=2.
- HOLDOFF_CYCLES, 3: minimum cycles after an ack before another ack may issue, 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- irq  in  NUM_IRQ  raw asynchronous interrupt lines
- irq_enable  in  NUM_IRQ  per-source enable (mie bits)
- global_ie  in  1  mstatus.MIE
- pending_clear  in  NUM_IRQ  one-cycle software clear of edge-pending bits
- valid_m  in  1  M stage holds a real (non-bubble) instruction
- pc_m  in  32  PC of the M-stage instruction
- exception_m  in  1  synchronous exception in M
- exception_e  in  1  synchronous exception in E
- csr_write_m  in  1  CSR write in M
- int_ack  out  1  take interrupt this cycle (flushes D/E/M)
- int_cause  out  32  mcause value, valid while int_ack=1
- int_epc  out  32  mepc value, valid while int_ack=1
- pending  out  NUM_IRQ  mip readout

Behaviour:
- Reset (async, rst_n=0):
  - synchronisers, edge-detect flops and pending = 0
  - state = IDLE, holdoff counter = 0
  - int_ack = 0, int_cause = 0, int_epc = 0
- Synchronisation: irq passes through SYNC_STAGES flops. s_i denotes synchronised line i; p_i denotes its previous value.
- Pending, level source (EDGE_MASK[i]=0):
  - pending[i] = s_i, registered.
  - pending_clear has no effect.
- Pending, edge source (EDGE_MASK[i]=1):
  - Set on s_i & ~p_i.
  - Cleared on pending_clear[i], or on the ack cycle for source i.
  - A set and a clear in the same cycle leave the bit set (the new edge wins).
- Candidate: req = pending & irq_enable, qualified by global_ie. Priority goes to the lowest index.
- Safe point: valid_m & ~exception_m & ~exception_e & ~csr_write_m.
  - Exceptions always win over interrupts.
  - A CSR write in M may be modifying enables.
- FSM:
  - IDLE: when global_ie & |req, go to ARMED.
  - ARMED:
    - If req drops or global_ie drops, go to IDLE with no ack.
    - Otherwise, if the safe point is true, go to ACK.
    - Otherwise stay in ARMED.
  - ACK: lasts exactly one cycle.
    - int_ack = 1; int_cause = {1'b1, 26'b0, 5'(16 + k)}, where k is the selected index.
    - int_epc = pc_m.
    - An edge source clears pending[k].
    - The holdoff counter loads HOLDOFF_CYCLES; next state is HOLDOFF.
  - HOLDOFF: the counter decrements each cycle. At 0, go to IDLE. No ack is possible in this state; this covers the latency of the CSR file clearing mstatus.MIE.
- Timing of int_ack and its outputs:
  - int_ack is a registered output, high for exactly one cycle per taken interrupt.
  - int_cause and int_epc are registered in the same cycle. They hold their value until the next ack and do not return to 0.
  - Source selection and pc_m are sampled in the cycle the ARMED-to-ACK transition is taken. A change in req during that cycle does not alter the selected source.
- Latency: from a raw irq rising edge to int_ack is SYNC_STAGES + 3 cycles minimum: sync, pending, ARMED, ACK.
- A level source deasserting while in ARMED abandons the request; no spurious ack is issued.
- A reset asserted mid-ACK or mid-HOLDOFF returns to the reset values immediately.

Test Plan:
- Edge IRQ: NUM_IRQ=4, EDGE_MASK=4'b0001, global_ie=1, irq_enable=4'hF, valid_m=1, pc_m=0x100.
  - Stimulus: pulse irq[0] for 1 cycle.
  - Response: int_ack high for 1 cycle at SYNC_STAGES+3 cycles after the edge; int_cause=0x80000010, int_epc=0x100; pending[0]=0 afterwards.
- Priority: irq[1] and irq[3] (level) asserted in the same cycle.
  - Response: int_cause=0x80000011. While irq[3] is held, the next ack (int_cause=0x80000013) follows only after HOLDOFF_CYCLES, and only once irq[1] is dropped.
- Safe-point blocking: ARMED with exception_m=1 for 5 cycles, then valid_m=0 for 2 cycles.
  - Response: no int_ack during those 7 cycles. Ack in the cycle the safe point is true, with int_epc equal to the pc_m of that cycle.
- Gating and abandonment:
  - global_ie=0 while pending[2]=1 -> no ack; pending[2] stays visible.
  - Raising global_ie -> ack follows.
  - Level irq dropped while ARMED -> FSM returns to IDLE with no ack.
- Edge clear race: edge source 0, with pending_clear[0] and a new synchronised edge in the same cycle.
  - Response: pending[0] stays 1.
  - Reset mid-HOLDOFF: rst_n low forces int_ack=0 and pending=0 immediately.

Source files
------------

// File: rtl/cpu_interrupt_unit.sv
// Interrupt initiator: synchronises irq lines, keeps the mip pending register, and issues a
// one-cycle int_ack with mcause/mepc when the pipeline reaches a safe point.
module cpu_interrupt_unit #(
    parameter int unsigned          NUM_IRQ        = 4,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK      = '0,
    parameter int unsigned          SYNC_STAGES    = 2,
    parameter int unsigned          HOLDOFF_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic               global_ie,
    input  logic [NUM_IRQ-1:0] pending_clear,
    input  logic               valid_m,
    input  logic [31:0]        pc_m,
    input  logic               exception_m,
    input  logic               exception_e,
    input  logic               csr_write_m,
    output logic               int_ack,
    output logic [31:0]        int_cause,
    output logic [31:0]        int_epc,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {StIdle, StArmed, StAck, StHoldoff} state_e;

    state_e                             state_q, state_d;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0]                 prev_q;
    logic [NUM_IRQ-1:0]                 pending_q, pending_d;
    logic [NUM_IRQ-1:0]                 sync_line, rise, req, ack_clr;
    logic [3:0]                         hold_q, hold_d;
    logic [3:0]                         sel_q, sel_idx;
    logic                               ack_q;
    logic [31:0]                        cause_q, epc_q;
    logic                               go, safe, take;

    assign sync_line = sync_q[SYNC_STAGES-1];
    assign rise      = sync_line & ~prev_q;
    assign req       = pending_q & irq_enable;
    assign go        = global_ie & (|req);
    assign safe      = valid_m & ~exception_m & ~exception_e & ~csr_write_m;

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) sel_idx = 4'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                pending_d[i] = rise[i] | (pending_q[i] & ~pending_clear[i] & ~ack_clr[i]);
            end else begin
                pending_d[i] = sync_line[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], irq};
            prev_q    <= sync_line;
            pending_q <= pending_d;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (go) state_d = StArmed;
            end
            StArmed: begin
                if (!go) begin
                    state_d = StIdle;
                end else if (safe) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StHoldoff;
                hold_d  = 4'(HOLDOFF_CYCLES);
            end
            StHoldoff: begin
                if (hold_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: take fires on the ARMED->ACK transition, ack_clr during the ACK cycle.
    always_comb begin
        take = (state_q == StArmed) & go & safe;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_clr[i] = (state_q == StAck) && (sel_q == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            cause_q <= '0;
            epc_q   <= '0;
            sel_q   <= '0;
        end else begin
            ack_q <= take;
            if (take) begin
                cause_q <= {1'b1, 26'b0, 1'b1, sel_idx};
                epc_q   <= pc_m;
                sel_q   <= sel_idx;
            end
        end
    end

    assign int_ack   = ack_q;
    assign int_cause = cause_q;
    assign int_epc   = epc_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_cpu_interrupt_unit.sv
// Randomised and directed bench for cpu_interrupt_unit against a behavioural model that tracks
// synchronised lines, pending bits, an armed flag and a post-ack blocking window.
module tb_cpu_interrupt_unit;

    localparam int unsigned NUM   = 4;
    localparam logic [3:0]  EDGE  = 4'b0001;
    localparam int unsigned SYNC  = 2;
    localparam int unsigned HOLD  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  irq, irq_enable, pending_clear, pending;
    logic        global_ie, valid_m, exception_m, exception_e, csr_write_m;
    logic [31:0] pc_m, int_cause, int_epc;
    logic        int_ack;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [3:0]  m_hist[$];
    logic [3:0]  m_pend;
    bit          m_armed;
    int          m_block;
    bit          m_ack;
    int          m_sel;
    logic [31:0] m_cause, m_epc;

    cpu_interrupt_unit #(
        .NUM_IRQ(NUM), .EDGE_MASK(EDGE), .SYNC_STAGES(SYNC), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .irq_enable(irq_enable), .global_ie(global_ie),
        .pending_clear(pending_clear), .valid_m(valid_m), .pc_m(pc_m),
        .exception_m(exception_m), .exception_e(exception_e), .csr_write_m(csr_write_m),
        .int_ack(int_ack), .int_cause(int_cause), .int_epc(int_epc), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i <= SYNC; i++) m_hist.push_back(4'b0);
        m_pend  = '0;
        m_armed = 0;
        m_block = 0;
        m_ack   = 0;
        m_sel   = 0;
        m_cause = '0;
        m_epc   = '0;
    endtask

    // One clock edge of the specified behaviour, using the inputs held across the edge.
    task automatic model_step();
        logic [3:0] s, p, rq, np;
        bit go, safe, new_ack;
        int k;
        s    = m_hist[SYNC-1];
        p    = m_hist[SYNC];
        rq   = m_pend & irq_enable;
        go   = global_ie && (rq != 0);
        safe = valid_m && !exception_m && !exception_e && !csr_write_m;
        new_ack = 0;
        k = 0;
        if (m_block > 0) begin
            m_block--;
        end else if (m_armed) begin
            if (!go) begin
                m_armed = 0;
            end else if (safe) begin
                while (!rq[k]) k++;
                new_ack = 1;
                m_cause = 32'h8000_0000 + 32'(16 + k);
                m_epc   = pc_m;
                m_block = HOLD + 2;  // ACK cycle, HOLD+1 holdoff cycles, then idle
                m_armed = 0;
            end
        end else if (go) begin
            m_armed = 1;
        end
        for (int i = 0; i < NUM; i++) begin
            if (EDGE[i]) begin
                np[i] = (s[i] & ~p[i]) |
                        (m_pend[i] & ~pending_clear[i] & ~(m_ack && m_sel == i));
            end else begin
                np[i] = s[i];
            end
        end
        m_pend = np;
        if (new_ack) m_sel = k;
        m_ack = new_ack;
        m_hist.push_front(irq);
        void'(m_hist.pop_back());
    endtask

    task automatic check_all();
        chk("int_ack", {31'b0, int_ack}, {31'b0, m_ack});
        chk("pending", {28'b0, pending}, {28'b0, m_pend});
        chk("int_cause", int_cause, m_cause);
        chk("int_epc", int_epc, m_epc);
    endtask

    // Advance one clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_ack(input int bound, output int n);
        bit got;
        got = 0;
        n = 0;
        while (!got && n < bound) begin
            cycle();
            n++;
            if (int_ack) got = 1;
        end
        chk("ack_within_bound", {31'b0, got}, 32'd1);
    endtask

    task automatic count_acks(input int cycles, inout int acks);
        for (int i = 0; i < cycles; i++) begin
            cycle();
            if (int_ack) acks++;
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must drop before the next edge.
    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, "_ack"}, {31'b0, int_ack}, 32'd0);
        chk({tag, "_pending"}, {28'b0, pending}, 32'd0);
        chk({tag, "_cause"}, int_cause, 32'd0);
        chk({tag, "_epc"}, int_epc, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n, n2, acks;
        rst_n = 1'b0;
        irq = '0; irq_enable = 4'hF; pending_clear = '0;
        global_ie = 1'b1; valid_m = 1'b1; exception_m = 1'b0; exception_e = 1'b0;
        csr_write_m = 1'b0; pc_m = 32'h100;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, int_ack}, 32'd0);
        chk("rst_pending", {28'b0, pending}, 32'd0);
        chk("rst_cause", int_cause, 32'd0);
        chk("rst_epc", int_epc, 32'd0);
        rst_n = 1'b1;
        repeat (3) cycle();

        // Edge source 0: one-cycle pulse, ack SYNC+3 cycles later
        irq[0] = 1'b1;
        cycle();
        irq[0] = 1'b0;
        wait_ack(12, n);
        chk("edge_latency", 32'(n + 1), 32'd5);
        chk("edge_cause", int_cause, 32'h8000_0010);
        chk("edge_epc", int_epc, 32'h100);
        cycle(); cycle();
        chk("edge_pending_cleared", {31'b0, pending[0]}, 32'd0);
        repeat (8) cycle();

        // Priority between level sources 1 and 3
        irq[1] = 1'b1; irq[3] = 1'b1;
        wait_ack(15, n);
        chk("prio_cause_first", int_cause, 32'h8000_0011);
        irq[1] = 1'b0;
        wait_ack(20, n2);
        chk("prio_cause_second", int_cause, 32'h8000_0013);
        chk("prio_holdoff_gap", {31'b0, n2 > int'(HOLD)}, 32'd1);
        irq[3] = 1'b0;
        repeat (10) cycle();

        // Safe-point blocking
        acks = 0;
        exception_m = 1'b1; irq[2] = 1'b1;
        count_acks(10, acks);
        count_acks(5, acks);
        exception_m = 1'b0; valid_m = 1'b0;
        count_acks(2, acks);
        chk("safe_blocked", 32'(acks), 32'd0);
        valid_m = 1'b1; pc_m = 32'h240;
        cycle();
        chk("safe_ack", {31'b0, int_ack}, 32'd1);
        chk("safe_epc", int_epc, 32'h240);
        chk("safe_cause", int_cause, 32'h8000_0012);
        irq[2] = 1'b0; pc_m = 32'h100;
        repeat (10) cycle();

        // Global enable gating
        acks = 0;
        global_ie = 1'b0; irq[2] = 1'b1;
        count_acks(8, acks);
        chk("gate_no_ack", 32'(acks), 32'd0);
        chk("gate_pending_visible", {31'b0, pending[2]}, 32'd1);
        global_ie = 1'b1;
        wait_ack(5, n);
        chk("gate_cause", int_cause, 32'h8000_0012);
        irq[2] = 1'b0;
        repeat (10) cycle();

        // Level source abandoned while ARMED
        acks = 0;
        exception_m = 1'b1; irq[3] = 1'b1;
        count_acks(6, acks);
        irq[3] = 1'b0;
        count_acks(8, acks);
        exception_m = 1'b0;
        count_acks(6, acks);
        chk("abandon_no_ack", 32'(acks), 32'd0);

        // Edge set and software clear in the same cycle: the edge wins
        global_ie = 1'b0;
        irq[0] = 1'b1;
        repeat (4) cycle();
        irq[0] = 1'b0;
        repeat (2) cycle();
        chk("race_pre_pending", {31'b0, pending[0]}, 32'd1);
        irq[0] = 1'b1;
        cycle(); cycle();
        pending_clear[0] = 1'b1;
        cycle();
        pending_clear[0] = 1'b0;
        chk("race_edge_wins", {31'b0, pending[0]}, 32'd1);
        irq[0] = 1'b0;
        repeat (4) cycle();
        pending_clear[0] = 1'b1;
        cycle();
        pending_clear[0] = 1'b0;
        chk("clear_alone", {31'b0, pending[0]}, 32'd0);
        global_ie = 1'b1;
        repeat (3) cycle();

        // Reset mid-ACK with another source pending
        irq_enable = 4'b0001; irq[3] = 1'b1;
        irq[0] = 1'b1;
        cycle();
        irq[0] = 1'b0;
        wait_ack(12, n);
        chk("midack_pending3", {31'b0, pending[3]}, 32'd1);
        reset_now("midack");
        irq[3] = 1'b0; irq_enable = 4'hF;
        repeat (3) cycle();

        // Reset mid-HOLDOFF
        irq[0] = 1'b1;
        cycle();
        irq[0] = 1'b0;
        wait_ack(12, n);
        cycle(); cycle();
        reset_now("midhold");
        repeat (3) cycle();

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NUM; i++) begin
                if ($urandom_range(7) == 0) irq[i] = ~irq[i];
            end
            if ($urandom_range(31) == 0) irq_enable = 4'($urandom);
            global_ie     = ($urandom_range(15) != 0);
            pending_clear = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
            valid_m       = ($urandom_range(3) != 0);
            exception_m   = ($urandom_range(9) == 0);
            exception_e   = ($urandom_range(9) == 0);
            csr_write_m   = ($urandom_range(9) == 0);
            pc_m          = $urandom & 32'hFFFF_FFFC;
            if (c == 2000) reset_now("rand_rst");
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
